// File: rtl/green_pkg.sv
// rtl/green_pkg.sv - shared types and constants for the green accumulator datapath
package green_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    localparam logic [15:0] HALT_OP = 16'hFFFF;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        HALT
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BR
    } pc_sel_t;

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - next-PC select: hold, increment (wrapping) or branch target
module pc_gen
    import green_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  pc_sel_t           sel,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        unique case (sel)
            PC_INC:  next_pc = pc + ADDR_W'(1);
            PC_BR:   next_pc = br_target;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: PC, imem read control, branch redirect
// Optional HALT-word stop is compiled in with PC_FETCH_HALT_EN.
module pc_fetch
    import green_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               stall,
    input  logic               BR_in,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] opCode,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               valid,
    output logic               halted
);

    fetch_state_t      state, next_state;
    pc_sel_t           pc_sel;
    logic [ADDR_W-1:0] pc, next_pc;
    logic              not_halted;
    logic              redirect;
    logic              advance;
    logic              halt_now;

`ifdef PC_FETCH_HALT_EN
    logic halted_q;

    assign not_halted = (state != HALT);
    assign halt_now   = advance & valid & (imem_rdata == INSTR_W'(HALT_OP));
    assign halted     = halted_q;
`else
    assign not_halted = 1'b1;
    assign halt_now   = 1'b0;
    assign halted     = 1'b0;
`endif

    // A redirect takes priority over stall; the bubble it creates satisfies the stall.
    assign redirect  = en & valid & BR_in & not_halted;
    assign advance   = en & ~stall & ~redirect & not_halted;
    assign imem_en   = en & (~stall | redirect) & not_halted;
    assign imem_addr = pc;
    assign opCode    = imem_rdata;

    always_comb begin
        next_state = state;
        pc_sel     = PC_HOLD;
        unique case (state)
            FILL: begin
                if (advance) begin
                    next_state = RUN;
                    pc_sel     = PC_INC;
                end
            end
            RUN: begin
                if (redirect) begin
                    next_state = FILL;
                    pc_sel     = PC_BR;
                end else if (halt_now) begin
                    next_state = HALT;
                end else if (advance) begin
                    pc_sel     = PC_INC;
                end
            end
            default: begin
                next_state = state;
                pc_sel     = PC_HOLD;
            end
        endcase
    end

    pc_gen #(
        .ADDR_W (ADDR_W)
    ) u_pc_gen (
        .sel       (pc_sel),
        .pc        (pc),
        .br_target (br_target),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            pc     <= RESET_PC;
            pc_out <= '0;
            valid  <= 1'b0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (redirect || halt_now) begin
                valid <= 1'b0;
            end else if (advance) begin
                valid  <= 1'b1;
                pc_out <= pc;
            end
        end
    end

`ifdef PC_FETCH_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else if (halt_now) begin
            halted_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed vector bench for pc_fetch with a synchronous-read memory model
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        stall;
    logic        BR_in;
    logic [7:0]  br_target;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [15:0] imem_rdata;
    logic [15:0] opCode;
    logic [7:0]  pc_out;
    logic        valid;
    logic        halted;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    pc_fetch #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .stall      (stall),
        .BR_in      (BR_in),
        .br_target  (br_target),
        .imem_addr  (imem_addr),
        .imem_en    (imem_en),
        .imem_rdata (imem_rdata),
        .opCode     (opCode),
        .pc_out     (pc_out),
        .valid      (valid),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic        en;
        logic        stall;
        logic        br;
        logic [7:0]  tgt;
        logic        x_imem_en;
        logic        x_valid;
        logic [7:0]  x_pc_out;
        logic [7:0]  x_addr;
        logic        chk_op;
        logic [15:0] x_op;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic e, input logic s, input logic b, input logic [7:0] t);
        en        = e;
        stall     = s;
        BR_in     = b;
        br_target = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic e, input logic s, input logic b, input logic [7:0] t,
                                input logic xe, input logic xv, input logic [7:0] xp,
                                input logic [7:0] xa, input logic co, input logic [15:0] xo);
        vec_t v;
        v.en = e; v.stall = s; v.br = b; v.tgt = t;
        v.x_imem_en = xe; v.x_valid = xv; v.x_pc_out = xp; v.x_addr = xa;
        v.chk_op = co; v.x_op = xo;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

        //              en   st   br   tgt    imem valid pc_out addr  chk  op
        vecs[0]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h00, 8'h01, 1'b1,16'h1000);
        vecs[1]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h01, 8'h02, 1'b1,16'h1001);
        vecs[2]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h02, 8'h03, 1'b1,16'h1002);
        vecs[3]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h03, 8'h04, 1'b1,16'h1003);
        vecs[4]  = mk(1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1, 8'h03, 8'h04, 1'b1,16'h1003);
        vecs[5]  = mk(1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1, 8'h03, 8'h04, 1'b1,16'h1003);
        vecs[6]  = mk(1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1, 8'h03, 8'h04, 1'b1,16'h1003);
        vecs[7]  = mk(1'b1,1'b1,1'b0,8'h00, 1'b0,1'b1, 8'h03, 8'h04, 1'b1,16'h1003);
        vecs[8]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h04, 8'h05, 1'b1,16'h1004);
        vecs[9]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h05, 8'h06, 1'b1,16'h1005);
        vecs[10] = mk(1'b1,1'b0,1'b1,8'h40, 1'b1,1'b0, 8'h05, 8'h40, 1'b0,16'h0000);
        vecs[11] = mk(1'b1,1'b0,1'b1,8'h77, 1'b1,1'b1, 8'h40, 8'h41, 1'b1,16'h1040);
        vecs[12] = mk(1'b1,1'b1,1'b1,8'h10, 1'b1,1'b0, 8'h40, 8'h10, 1'b0,16'h0000);
        vecs[13] = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h10, 8'h11, 1'b1,16'h1010);
        vecs[14] = mk(1'b0,1'b0,1'b1,8'h22, 1'b0,1'b1, 8'h10, 8'h11, 1'b1,16'h1010);
        vecs[15] = mk(1'b1,1'b0,1'b1,8'hFE, 1'b1,1'b0, 8'h10, 8'hFE, 1'b0,16'h0000);
        vecs[16] = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'hFE, 8'hFF, 1'b1,16'h10FE);
        vecs[17] = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'hFF, 8'h00, 1'b1,16'h10FF);
        vecs[18] = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h00, 8'h01, 1'b1,16'h1000);
        vecs[19] = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,1'b1, 8'h01, 8'h02, 1'b1,16'h1001);

        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        step();
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_pc_out", 32'(pc_out), 32'h0);
        chk("rst_imem_addr", 32'(imem_addr), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].en, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            #1;
            chk($sformatf("v%0d_imem_en", i), 32'(imem_en), 32'(vecs[i].x_imem_en));
            step();
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].x_valid));
            chk($sformatf("v%0d_pc_out", i), 32'(pc_out), 32'(vecs[i].x_pc_out));
            chk($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].x_addr));
            if (vecs[i].chk_op)
                chk($sformatf("v%0d_opcode", i), 32'(opCode), 32'(vecs[i].x_op));
        end

        // asynchronous reset in the middle of a cycle while running
        do_reset();
        for (int i = 0; i < 10; i++) step();
        chk("mid_pre_pc_out", 32'(pc_out), 32'h09);
        chk("mid_pre_opcode", 32'(opCode), 32'h1009);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", 32'(valid), 32'h0);
        chk("mid_async_imem_addr", 32'(imem_addr), 32'h0);
        chk("mid_async_pc_out", 32'(pc_out), 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        chk("mid_restart_valid", 32'(valid), 32'h1);
        chk("mid_restart_pc_out", 32'(pc_out), 32'h0);
        chk("mid_restart_opcode", 32'(opCode), 32'h1000);
        step();
        chk("mid_restart_op1", 32'(opCode), 32'h1001);

        // all-ones word at address 7
        mem[7] = 16'hFFFF;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        chk("halt_word_pc_out", 32'(pc_out), 32'h07);
        chk("halt_word_valid", 32'(valid), 32'h1);
        chk("halt_word_opcode", 32'(opCode), 32'hFFFF);
        step();
`ifdef PC_FETCH_HALT_EN
        chk("halt_valid", 32'(valid), 32'h0);
        chk("halt_halted", 32'(halted), 32'h1);
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 1'b0, 1'(i % 2), 8'h30);
            #1;
            chk($sformatf("halt%0d_imem_en", i), 32'(imem_en), 32'h0);
            step();
            chk($sformatf("halt%0d_valid", i), 32'(valid), 32'h0);
            chk($sformatf("halt%0d_halted", i), 32'(halted), 32'h1);
            chk($sformatf("halt%0d_imem_addr", i), 32'(imem_addr), 32'h08);
        end
        do_reset();
        step();
        chk("halt_exit_halted", 32'(halted), 32'h0);
        chk("halt_exit_valid", 32'(valid), 32'h1);
        chk("halt_exit_pc_out", 32'(pc_out), 32'h0);
        chk("halt_exit_opcode", 32'(opCode), 32'h1000);
`else
        chk("nohalt_valid", 32'(valid), 32'h1);
        chk("nohalt_halted", 32'(halted), 32'h0);
        chk("nohalt_pc_out", 32'(pc_out), 32'h08);
        chk("nohalt_opcode", 32'(opCode), 32'h1008);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
